viterbi_ctrl: RTL and testbench
===============================

VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter: TB_DEPTH, 15, trellis window depth in symbols (columns 0..TB_DEPTH-1).
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 start  in  1  one-cycle frame start request.
REQ-005 cfg_k  in  3  constraint length; legal 3..6.
REQ-006 frame_len  in  8  info symbols per frame; legal 1..255.
REQ-007 sym_valid  in  1  / sym_data  in  2  / sym_ready  out  1  encoded-symbol handshake.
REQ-008 acs_en  out  1  / acs_sym  out  2  / wr_col  out  4  ACS strobe, symbol, trellis column.
REQ-009 num_states  out  6  2^(cfg_k-1), held for the frame.
REQ-010 tb_start  out  1  / tb_flush  out  1  / tb_done  in  1  traceback-engine handshake.
REQ-011 busy  out  1  / frame_done  out  1  / cfg_err  out  1  status; frame_done and cfg_err are one-cycle pulses.

Function
REQ-012 States SHALL be IDLE, FILL, STEADY, TB_WAIT, FLUSH; all outputs registered.
REQ-013 IDLE: start with legal cfg_k and frame_len -> latch both, clear symbol count and column, busy=1, go FILL.
REQ-014 IDLE: start with illegal cfg_k (0-2, 7) or frame_len=0 -> cfg_err=1 for 1 cycle, stay IDLE, latched config unchanged.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 sym_ready=1 only in FILL and STEADY; sym_ready=0 in the cycle after any acceptance in STEADY (TB_WAIT entered).
REQ-017 Accept = sym_valid & sym_ready at edge t -> acs_en=1, acs_sym=sym_data, wr_col=current column during cycle t+1.
REQ-018 Column counter SHALL advance on each accept, wrapping TB_DEPTH-1 -> 0; symbol count saturates at frame_len.
REQ-019 FILL: on the accept that makes count=TB_DEPTH go STEADY; on the accept that makes count=frame_len (frame_len<=TB_DEPTH) go FLUSH (takes priority over STEADY).
REQ-020 STEADY: each accept -> TB_WAIT; tb_start=1 (tb_flush=0) in cycle t+2, one cycle only.
REQ-021 TB_WAIT: on tb_done=1 -> FLUSH if count=frame_len, else STEADY.
REQ-022 FLUSH: tb_start=1 with tb_flush=1 for one cycle on entry, then wait tb_done; on tb_done -> frame_done=1 one cycle, busy=0, IDLE.
REQ-023 tb_done in IDLE, FILL or STEADY SHALL be ignored; tb_done in the same cycle as tb_start SHALL be ignored.
REQ-024 num_states SHALL equal 1<<(cfg_k-1) from the cycle after a legal start; 4 when idle after reset.
REQ-025 sym_data in cycles without accept SHALL not affect acs_sym.

Reset
REQ-026 rst=1 SHALL force state IDLE, column 0, count 0, latched cfg_k=3, num_states=4, and all other outputs 0, immediately and regardless of state.
REQ-027 Reset mid-frame SHALL abandon the frame with no frame_done pulse; first cycle after release is IDLE.

Structure
REQ-028 Package viterbi_pkg SHALL hold the state enum, TB_DEPTH default, K_MIN=3, K_MAX=6, and symbol/column width constants.
REQ-029 One sub-module viterbi_col_ctr (modulo-TB_DEPTH column counter with clear/advance) SHALL be used; everything else is in viterbi_ctrl.

Verification
REQ-030 Reset mid-STEADY at count 20 -> all outputs 0 and state IDLE same cycle; no frame_done; clean new frame afterwards.
REQ-031 start, cfg_k=3, frame_len=20, sym_valid held 1 -> 15 back-to-back acs_en with wr_col 0..14, then 5 accept/tb_start/tb_done cycles with wr_col 0..4, one flush traceback, frame_done once.
REQ-032 cfg_k=6, frame_len=4 -> num_states=32, 4 acs_en, no non-flush tb_start, one tb_start with tb_flush=1, frame_done after tb_done.
REQ-033 start with cfg_k=7, then cfg_k=2, then frame_len=0 -> cfg_err pulse each time, busy stays 0.
REQ-034 In STEADY, tb_done held 0 for 10 cycles -> sym_ready=0 throughout, no acs_en; tb_done pulse -> sym_ready=1 next cycle.
REQ-035 Spurious tb_done in FILL and start during busy -> no state change, no extra tb_start, frame completes normally.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared definitions for the Viterbi decoder controller: FSM state encoding,
// trellis window depth default, constraint-length limits and field widths,
// plus the frame-configuration legality check used at frame start.
package viterbi_pkg;

    localparam int TB_DEPTH_DEF = 15;
    localparam int K_MIN        = 3;
    localparam int K_MAX        = 6;
    localparam int SYM_W        = 2;
    localparam int COL_W        = 4;
    localparam int LEN_W        = 8;
    localparam int NS_W         = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_STEADY  = 3'd2,
        ST_TB_WAIT = 3'd3,
        ST_FLUSH   = 3'd4
    } state_t;

    function automatic logic cfg_legal(input logic [2:0] k, input logic [LEN_W-1:0] len);
        return (int'(k) >= K_MIN) && (int'(k) <= K_MAX) && (len != '0);
    endfunction

endpackage

// File: rtl/viterbi_col_ctr.sv
// viterbi_col_ctr
// Trellis column pointer: counts 0..DEPTH-1 and wraps.
// Ports:
//   clk, rst  - clock, async active-high reset (column returns to 0)
//   clr_i     - synchronous clear to column 0 (has priority over adv_i)
//   adv_i     - advance one column
//   col_o     - current column
module viterbi_col_ctr
    import viterbi_pkg::*;
#(
    parameter int DEPTH = TB_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [COL_W-1:0] col_o
);

    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        col_d = col_q;
        if (clr_i) begin
            col_d = '0;
        end else if (adv_i) begin
            col_d = (col_q == COL_W'(DEPTH - 1)) ? '0 : col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) col_q <= '0;
        else     col_q <= col_d;
    end

    assign col_o = col_q;

endmodule

// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl
// Frame sequencer for a Viterbi decoder: accepts encoded symbols, strobes the
// ACS array with symbol and trellis column, and hands the survivor memory to
// the traceback engine (periodic tracebacks once the window is full, one
// flush traceback at frame end).
// Ports:
//   clk, rst                          - clock, async active-high reset
//   start, cfg_k, frame_len           - frame start request and its config
//   sym_valid, sym_data, sym_ready    - encoded-symbol handshake
//   acs_en, acs_sym, wr_col           - ACS strobe, symbol, trellis column
//   num_states                        - 2^(K-1) of the latched configuration
//   tb_start, tb_flush, tb_done       - traceback-engine handshake
//   busy, frame_done, cfg_err         - status (frame_done/cfg_err are pulses)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a legal start
// ST_FILL    | accepting symbols until the window holds TB_DEPTH columns
// ST_STEADY  | window full; accept one symbol, then trace back
// ST_TB_WAIT | periodic traceback in progress, symbol input stalled
// ST_FLUSH   | final flush traceback, then frame_done
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        cfg_k,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym_data,
    output logic              sym_ready,
    output logic              acs_en,
    output logic [SYM_W-1:0]  acs_sym,
    output logic [COL_W-1:0]  wr_col,
    output logic [NS_W-1:0]   num_states,
    output logic              tb_start,
    output logic              tb_flush,
    input  logic              tb_done,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d, cnt_inc;
    // num_states doubles as the latched constraint length (reset value 4 <-> K=3)
    logic [NS_W-1:0]    ns_q, ns_d;
    logic               pend_q, pend_d;
    logic               sym_ready_q, sym_ready_d, acs_en_q, acs_en_d;
    logic [SYM_W-1:0]   acs_sym_q, acs_sym_d;
    logic [COL_W-1:0]   wr_col_q, wr_col_d, col;
    logic               tb_start_q, tb_start_d, tb_flush_q, tb_flush_d;
    logic               busy_q, busy_d, frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;
    logic               accept, start_ok, start_bad, done_ok;

    assign accept    = sym_valid & sym_ready_q;
    assign start_ok  = start & (state_q == ST_IDLE) & cfg_legal(cfg_k, frame_len);
    assign start_bad = start & (state_q == ST_IDLE) & ~cfg_legal(cfg_k, frame_len);
    // A traceback is only considered finished once it has actually been launched.
    assign done_ok   = tb_done & ~pend_q & ~tb_start_q;
    assign cnt_inc   = (cnt_q == len_q) ? cnt_q : cnt_q + LEN_W'(1);

    viterbi_col_ctr #(.DEPTH(TB_DEPTH)) u_col_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_ok),
        .adv_i (accept),
        .col_o (col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_ok) state_d = ST_FILL;
            ST_FILL: begin
                if (accept) begin
                    if (cnt_inc == len_q)                     state_d = ST_FLUSH;
                    else if (cnt_inc == LEN_W'(TB_DEPTH))     state_d = ST_STEADY;
                end
            end
            ST_STEADY:  if (accept) state_d = ST_TB_WAIT;
            ST_TB_WAIT: if (done_ok) state_d = (cnt_q == len_q) ? ST_FLUSH : ST_STEADY;
            ST_FLUSH:   if (done_ok) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sym_ready_d  = (state_d == ST_FILL) || (state_d == ST_STEADY);
        busy_d       = (state_d != ST_IDLE);
        acs_en_d     = accept;
        acs_sym_d    = accept ? sym_data : acs_sym_q;
        wr_col_d     = accept ? col : wr_col_q;
        // Traceback launch waits one cycle after entry so the last ACS column
        // is written before the engine reads the survivor memory.
        pend_d       = (state_d != state_q) &&
                       ((state_d == ST_TB_WAIT) || (state_d == ST_FLUSH));
        tb_start_d   = pend_q;
        tb_flush_d   = pend_q && (state_q == ST_FLUSH);
        frame_done_d = (state_q == ST_FLUSH) && done_ok;
        cfg_err_d    = start_bad;
        cnt_d        = cnt_q;
        len_d        = len_q;
        ns_d         = ns_q;
        if (start_ok) begin
            cnt_d = '0;
            len_d = frame_len;
            ns_d  = NS_W'(1) << (cfg_k - 3'd1);
        end else if (accept) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            len_q        <= '0;
            ns_q         <= NS_W'(4);
            pend_q       <= 1'b0;
            sym_ready_q  <= 1'b0;
            acs_en_q     <= 1'b0;
            acs_sym_q    <= '0;
            wr_col_q     <= '0;
            tb_start_q   <= 1'b0;
            tb_flush_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            ns_q         <= ns_d;
            pend_q       <= pend_d;
            sym_ready_q  <= sym_ready_d;
            acs_en_q     <= acs_en_d;
            acs_sym_q    <= acs_sym_d;
            wr_col_q     <= wr_col_d;
            tb_start_q   <= tb_start_d;
            tb_flush_q   <= tb_flush_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign sym_ready  = sym_ready_q;
    assign acs_en     = acs_en_q;
    assign acs_sym    = acs_sym_q;
    assign wr_col     = wr_col_q;
    assign num_states = ns_q;
    assign tb_start   = tb_start_q;
    assign tb_flush   = tb_flush_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl
// Self-checking bench for viterbi_ctrl. A single process advances the clock
// through tick(), which observes DUT outputs, scores ACS strobes against a
// queue of accepted symbols, and drives the symbol source and a simple
// traceback-engine responder.
module tb_viterbi_ctrl;

    localparam int DEPTH = 15;

    typedef struct packed {
        logic [1:0] sym;
        logic [3:0] col;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] cfg_k = 3'd3;
    logic [7:0] frame_len = 8'd1;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_data = 2'd0;
    logic       tb_done = 1'b0;
    logic       sym_ready, acs_en, tb_start, tb_flush, busy, frame_done, cfg_err;
    logic [1:0] acs_sym;
    logic [3:0] wr_col;
    logic [5:0] num_states;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, last_acs_cyc = -10;
    int acs_cnt = 0, tbs_cnt = 0, tbf_cnt = 0, fd_cnt = 0, err_cnt = 0;
    int feed_sent = 0, feed_target = 0, frame_base = 0;
    int tb_cd = 0;
    bit auto_tb = 1'b0, pulse_done = 1'b0;
    logic [1:0] last_sym = 2'd0;
    exp_t sb_q[$];

    viterbi_ctrl #(.TB_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_k      (cfg_k),
        .frame_len  (frame_len),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .acs_en     (acs_en),
        .acs_sym    (acs_sym),
        .wr_col     (wr_col),
        .num_states (num_states),
        .tb_start   (tb_start),
        .tb_flush   (tb_flush),
        .tb_done    (tb_done),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (acs_en) begin
                acs_cnt++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL acs_unexpected: acs_en=1 at cycle %0d, required no strobe", cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (acs_sym !== e.sym || wr_col !== e.col) begin
                        n_fail++;
                        $display("FAIL acs_data: sym=%0d col=%0d, required sym=%0d col=%0d",
                                 acs_sym, wr_col, e.sym, e.col);
                    end
                end
                last_acs_cyc = cyc;
            end else begin
                n_checks++;
                if (acs_sym !== last_sym) begin
                    n_fail++;
                    $display("FAIL acs_sym_hold: acs_sym=%0d, required held %0d", acs_sym, last_sym);
                end
            end
            if (tb_start && !tb_flush) begin
                tbs_cnt++;
                n_checks++;
                if (cyc != last_acs_cyc + 1) begin
                    n_fail++;
                    $display("FAIL tb_start_latency: %0d cycles after acs_en, required 1",
                             cyc - last_acs_cyc);
                end
            end
            if (tb_start && tb_flush) tbf_cnt++;
            if (tb_flush && !tb_start) begin
                n_fail++;
                $display("FAIL tb_flush_alone: tb_flush=1 tb_start=0, required tb_start=1");
            end
            if (frame_done) fd_cnt++;
            if (cfg_err) err_cnt++;
        end
        last_sym = acs_sym;
        // traceback engine responder
        tb_done = 1'b0;
        if (pulse_done) begin
            tb_done    = 1'b1;
            pulse_done = 1'b0;
        end else if (auto_tb) begin
            if (tb_start) tb_cd = 3;
            else if (tb_cd > 0) begin
                tb_cd--;
                if (tb_cd == 0) tb_done = 1'b1;
            end
        end
        // symbol source: valid held while symbols remain, data always random
        sym_data  = 2'($urandom_range(0, 3));
        sym_valid = (feed_sent < feed_target);
        if (sym_valid && sym_ready) begin
            e.sym = sym_data;
            e.col = 4'((feed_sent - frame_base) % DEPTH);
            sb_q.push_back(e);
            feed_sent++;
        end
    endtask

    task automatic start_frame(input logic [2:0] k, input logic [7:0] len);
        cfg_k       = k;
        frame_len   = len;
        frame_base  = feed_sent;
        feed_target = feed_sent + int'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fd(input int limit);
        int f0 = fd_cnt;
        for (int i = 0; i < limit && fd_cnt == f0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({busy, sym_ready, acs_en, tb_start, tb_flush, frame_done, cfg_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: %b, required 0000000",
                     {busy, sym_ready, acs_en, tb_start, tb_flush, frame_done, cfg_err});
        end
        n_checks++;
        if (wr_col !== 4'd0 || acs_sym !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: wr_col=%0d acs_sym=%0d, required 0 0", wr_col, acs_sym);
        end
        n_checks++;
        if (num_states !== 6'd4) begin
            n_fail++;
            $display("FAIL reset_num_states: %0d, required 4", num_states);
        end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%0d sym_ready=%0d, required 0 0", busy, sym_ready);
        end
    endtask

    task automatic test_cfg_err();
        logic [2:0] ks[3]   = '{3'd7, 3'd2, 3'd3};
        logic [7:0] lens[3] = '{8'd10, 8'd10, 8'd0};
        for (int i = 0; i < 3; i++) begin
            int e0 = err_cnt;
            cfg_k     = ks[i];
            frame_len = lens[i];
            start = 1'b1;
            tick();
            start = 1'b0;
            n_checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_pulse[%0d]: cfg_err=%0d busy=%0d, required 1 0", i, cfg_err, busy);
            end
            tick();
            tick();
            n_checks++;
            if (err_cnt - e0 != 1 || busy !== 1'b0 || num_states !== 6'd4) begin
                n_fail++;
                $display("FAIL cfg_err_once[%0d]: pulses=%0d busy=%0d ns=%0d, required 1 0 4",
                         i, err_cnt - e0, busy, num_states);
            end
        end
    endtask

    task automatic test_long_frame();
        int a0 = acs_cnt, s0 = tbs_cnt, f0 = tbf_cnt, d0 = fd_cnt;
        int consec = 0, maxc = 0;
        auto_tb = 1'b1;
        start_frame(3'd3, 8'd20);
        n_checks++;
        if (num_states !== 6'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL long_start: ns=%0d busy=%0d, required 4 1", num_states, busy);
        end
        for (int i = 0; i < 400 && fd_cnt == d0; i++) begin
            tick();
            consec = acs_en ? consec + 1 : 0;
            if (consec > maxc) maxc = consec;
        end
        n_checks++;
        if (acs_cnt - a0 != 20 || tbs_cnt - s0 != 5 || tbf_cnt - f0 != 1) begin
            n_fail++;
            $display("FAIL long_counts: acs=%0d tb=%0d flush=%0d, required 20 5 1",
                     acs_cnt - a0, tbs_cnt - s0, tbf_cnt - f0);
        end
        // 15 FILL accepts plus the first STEADY accept arrive on consecutive edges
        n_checks++;
        if (maxc != 16) begin
            n_fail++;
            $display("FAIL long_burst: longest acs run %0d, required 16", maxc);
        end
        repeat (3) tick();
        n_checks++;
        if (fd_cnt - d0 != 1 || busy !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL long_done: frame_done=%0d busy=%0d pending=%0d, required 1 0 0",
                     fd_cnt - d0, busy, sb_q.size());
        end
    endtask

    task automatic test_short_frame();
        int a0 = acs_cnt, s0 = tbs_cnt, f0 = tbf_cnt, d0 = fd_cnt;
        auto_tb = 1'b1;
        start_frame(3'd6, 8'd4);
        n_checks++;
        if (num_states !== 6'd32) begin
            n_fail++;
            $display("FAIL short_num_states: %0d, required 32", num_states);
        end
        wait_fd(200);
        n_checks++;
        if (acs_cnt - a0 != 4 || tbs_cnt - s0 != 0 || tbf_cnt - f0 != 1 || fd_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL short_counts: acs=%0d tb=%0d flush=%0d done=%0d, required 4 0 1 1",
                     acs_cnt - a0, tbs_cnt - s0, tbf_cnt - f0, fd_cnt - d0);
        end
    endtask

    task automatic test_steady_stall();
        int a0 = acs_cnt, s0 = tbs_cnt, f0 = tbf_cnt, d0 = fd_cnt, a1;
        auto_tb = 1'b0;
        start_frame(3'd4, 8'd30);
        n_checks++;
        if (num_states !== 6'd8) begin
            n_fail++;
            $display("FAIL stall_num_states: %0d, required 8", num_states);
        end
        for (int i = 0; i < 100 && tbs_cnt == s0; i++) tick();
        n_checks++;
        if (tbs_cnt - s0 != 1 || acs_cnt - a0 != 16) begin
            n_fail++;
            $display("FAIL stall_entry: tb=%0d acs=%0d, required 1 16", tbs_cnt - s0, acs_cnt - a0);
        end
        a1 = acs_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (sym_ready !== 1'b0 || acs_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: sym_ready=%0d acs_en=%0d, required 0 0",
                         i, sym_ready, acs_en);
            end
        end
        pulse_done = 1'b1;
        tick();
        tick();
        n_checks++;
        if (sym_ready !== 1'b1 || acs_cnt != a1) begin
            n_fail++;
            $display("FAIL stall_release: sym_ready=%0d extra_acs=%0d, required 1 0",
                     sym_ready, acs_cnt - a1);
        end
        auto_tb = 1'b1;
        wait_fd(600);
        n_checks++;
        if (acs_cnt - a0 != 30 || tbs_cnt - s0 != 15 || tbf_cnt - f0 != 1 || fd_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL stall_counts: acs=%0d tb=%0d flush=%0d done=%0d, required 30 15 1 1",
                     acs_cnt - a0, tbs_cnt - s0, tbf_cnt - f0, fd_cnt - d0);
        end
    endtask

    task automatic test_spurious();
        int a0 = acs_cnt, s0 = tbs_cnt, f0 = tbf_cnt, d0 = fd_cnt, e0 = err_cnt;
        auto_tb = 1'b1;
        start_frame(3'd5, 8'd10);
        tick();
        tick();
        pulse_done = 1'b1;
        tick();
        tick();
        cfg_k     = 3'd3;
        frame_len = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_fd(200);
        n_checks++;
        if (acs_cnt - a0 != 10 || tbs_cnt - s0 != 0 || tbf_cnt - f0 != 1 || fd_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL spurious_counts: acs=%0d tb=%0d flush=%0d done=%0d, required 10 0 1 1",
                     acs_cnt - a0, tbs_cnt - s0, tbf_cnt - f0, fd_cnt - d0);
        end
        n_checks++;
        if (err_cnt != e0 || num_states !== 6'd16) begin
            n_fail++;
            $display("FAIL busy_start_ignored: cfg_err=%0d ns=%0d, required 0 16",
                     err_cnt - e0, num_states);
        end
    endtask

    task automatic test_reset_mid();
        int a0 = acs_cnt, s0 = tbs_cnt, d0, f0;
        auto_tb = 1'b1;
        start_frame(3'd3, 8'd40);
        feed_target = frame_base + 20;
        for (int i = 0; i < 400 && tbs_cnt - s0 < 5; i++) tick();
        for (int i = 0; i < 50 && sym_ready !== 1'b1; i++) tick();
        n_checks++;
        if (acs_cnt - a0 != 20 || sym_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: acs=%0d sym_ready=%0d busy=%0d, required 20 1 1",
                     acs_cnt - a0, sym_ready, busy);
        end
        d0 = fd_cnt;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, sym_ready, acs_en, tb_start, tb_flush, frame_done, cfg_err} !== 7'b0 ||
            wr_col !== 4'd0 || acs_sym !== 2'd0 || num_states !== 6'd4) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: flags=%b col=%0d sym=%0d ns=%0d, required 0 0 0 4",
                     {busy, sym_ready, acs_en, tb_start, tb_flush, frame_done, cfg_err},
                     wr_col, acs_sym, num_states);
        end
        tick();
        rst   = 1'b0;
        tb_cd = 0;
        repeat (5) tick();
        n_checks++;
        if (fd_cnt != d0 || busy !== 1'b0 || sym_ready !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_abandon: frame_done=%0d busy=%0d sym_ready=%0d, required 0 0 0",
                     fd_cnt - d0, busy, sym_ready);
        end
        a0 = acs_cnt;
        f0 = tbf_cnt;
        d0 = fd_cnt;
        start_frame(3'd4, 8'd6);
        wait_fd(200);
        n_checks++;
        if (acs_cnt - a0 != 6 || tbf_cnt - f0 != 1 || fd_cnt - d0 != 1 || num_states !== 6'd8) begin
            n_fail++;
            $display("FAIL mid_new_frame: acs=%0d flush=%0d done=%0d ns=%0d, required 6 1 1 8",
                     acs_cnt - a0, tbf_cnt - f0, fd_cnt - d0, num_states);
        end
    endtask

    initial begin
        test_reset();
        test_cfg_err();
        test_long_frame();
        test_short_frame();
        test_steady_stall();
        test_spurious();
        test_reset_mid();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
